// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-pipeline types and constants.
// State encoding, PC geometry and bubble counter width.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned ISS_W = 16;

  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch control/status bundle between the hazard unit
// and the sequencer.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic             stall_i;
  logic             br_taken_i;
  logic [PC_W-1:0]  br_target_i;
  logic             halt_i;
  logic             resume_i;
  logic [PC_W-1:0]  pc_o;
  logic [PC_W-1:0]  incre_pc_o;
  logic             ifid_en_o;
  logic             ifid_flush_o;
  logic             wb_ff_o;
  logic [1:0]       state_o;
  logic [ISS_W-1:0] issue_cnt_o;

  modport master (
    output stall_i, br_taken_i, br_target_i,
    output halt_i, resume_i,
    input  pc_o, incre_pc_o, ifid_en_o,
    input  ifid_flush_o, wb_ff_o, state_o,
    input  issue_cnt_o
  );

  modport slave (
    input  stall_i, br_taken_i, br_target_i,
    input  halt_i, resume_i,
    output pc_o, incre_pc_o, ifid_en_o,
    output ifid_flush_o, wb_ff_o, state_o,
    output issue_cnt_o
  );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != {W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC register, redirect,
// stall/halt control and IF/ID capture strobes.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic              CLK,
  input logic              RST,
  fetch_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] BUB_LD =
    CNT_W'(FLUSH_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nx;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nx;
  logic [CNT_W-1:0] r_bub;
  logic [CNT_W-1:0] w_bub_nx;
  logic             w_en;
  logic             w_fl;
  logic             w_wb;
  logic [PC_W-1:0]  w_inc;
  logic [ISS_W-1:0] w_iss;

  assign w_inc = r_pc + 1'b1;

  always_ff @(posedge CLK) begin
    r_state <= w_state_nx;
    r_pc    <= w_pc_nx;
    r_bub   <= w_bub_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_bub_nx   = r_bub;
    w_en       = 1'b0;
    w_fl       = 1'b0;
    w_wb       = 1'b0;
    if (RST) begin
      // reset cycle still pushes a bubble into IF/ID
      w_en       = 1'b1;
      w_fl       = 1'b1;
      w_state_nx = ST_RUN;
      w_pc_nx    = RESET_PC;
      w_bub_nx   = '0;
    end else begin
      unique case (r_state)
        ST_RUN, ST_STALL: begin
          if (bus.br_taken_i) begin
            w_en       = 1'b1;
            w_fl       = 1'b1;
            w_pc_nx    = bus.br_target_i;
            w_bub_nx   = BUB_LD;
            w_state_nx = ST_FLUSH;
          end else if (bus.halt_i) begin
            w_state_nx = ST_HALT;
          end else if (bus.stall_i) begin
            w_state_nx = ST_STALL;
          end else begin
            w_en       = 1'b1;
            w_wb       = 1'b1;
            w_pc_nx    = w_inc;
            w_state_nx = ST_RUN;
          end
        end
        ST_FLUSH: begin
          w_en = 1'b1;
          w_fl = 1'b1;
          if (bus.br_taken_i) begin
            w_pc_nx  = bus.br_target_i;
            w_bub_nx = BUB_LD;
          end else if (r_bub == '0) begin
            w_state_nx = ST_RUN;
          end else begin
            w_bub_nx = r_bub - 1'b1;
          end
        end
        ST_HALT: begin
          if (bus.resume_i && !bus.halt_i)
            w_state_nx = ST_RUN;
        end
        default: w_state_nx = ST_RUN;
      endcase
    end
  end

  sat_counter #(
    .W (ISS_W)
  ) u_iss (
    .CLK   (CLK),
    .i_clr (RST),
    .i_en  (w_wb),
    .o_cnt (w_iss)
  );

  assign bus.pc_o         = r_pc;
  assign bus.incre_pc_o   = w_inc;
  assign bus.ifid_en_o    = w_en;
  assign bus.ifid_flush_o = w_fl;
  assign bus.wb_ff_o      = w_wb;
  assign bus.state_o      = r_state;
  assign bus.issue_cnt_o  = w_iss;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised and directed bench for fetch_sequencer
// against a cycle-level behavioural model.
module tb_fetch_sequencer;

  localparam int FC = 2;
  localparam int M_RUN = 0, M_STALL = 1;
  localparam int M_FLUSH = 2, M_HALT = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .FLUSH_CYCLES (FC)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  int          m_pc;
  int          m_mode;
  int          m_bub;
  int          m_cnt;
  logic        e_en, e_fl, e_wb;

  logic [7:0]  o_pc, o_inc;
  logic        o_en, o_fl, o_wb;
  logic [1:0]  o_st;
  logic [15:0] o_cnt;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // what the block must present this cycle
  task automatic model_out();
    if (RST) begin
      e_en = 1; e_fl = 1; e_wb = 0;
    end else if (m_mode == M_FLUSH) begin
      e_en = 1; e_fl = 1; e_wb = 0;
    end else if (m_mode == M_HALT) begin
      e_en = 0; e_fl = 0; e_wb = 0;
    end else if (bus.br_taken_i) begin
      e_en = 1; e_fl = 1; e_wb = 0;
    end else if (bus.halt_i || bus.stall_i) begin
      e_en = 0; e_fl = 0; e_wb = 0;
    end else begin
      e_en = 1; e_fl = 0; e_wb = 1;
    end
  endtask

  task automatic model_step();
    if (RST) begin
      m_pc = 0; m_mode = M_RUN; m_bub = 0; m_cnt = 0;
      return;
    end
    if (e_wb && m_cnt < 65535) m_cnt++;
    if (m_mode == M_HALT) begin
      if (bus.resume_i && !bus.halt_i) m_mode = M_RUN;
    end else if (bus.br_taken_i) begin
      m_pc = bus.br_target_i;
      m_bub = FC - 1;
      m_mode = M_FLUSH;
    end else if (m_mode == M_FLUSH) begin
      if (m_bub == 0) m_mode = M_RUN;
      else m_bub--;
    end else if (bus.halt_i) begin
      m_mode = M_HALT;
    end else if (bus.stall_i) begin
      m_mode = M_STALL;
    end else begin
      m_pc = (m_pc + 1) % 256;
      m_mode = M_RUN;
    end
  endtask

  task automatic cyc(input logic rst, input logic br,
                     input logic [7:0] tgt,
                     input logic hlt, input logic stl,
                     input logic res);
    @(negedge CLK);
    RST = rst;
    bus.br_taken_i  = br;
    bus.br_target_i = tgt;
    bus.halt_i      = hlt;
    bus.stall_i     = stl;
    bus.resume_i    = res;
    #1;
    model_out();
    o_pc  = bus.pc_o;
    o_inc = bus.incre_pc_o;
    o_en  = bus.ifid_en_o;
    o_fl  = bus.ifid_flush_o;
    o_wb  = bus.wb_ff_o;
    o_st  = bus.state_o;
    o_cnt = bus.issue_cnt_o;
    if (m_mode >= 0) begin
      chk("pc",    o_pc,  m_pc);
      chk("inc",   o_inc, (m_pc + 1) % 256);
      chk("en",    o_en,  e_en);
      chk("flush", o_fl,  e_fl);
      chk("wb",    o_wb,  e_wb);
      chk("state", o_st,  m_mode);
      chk("issue", o_cnt, m_cnt);
    end
    @(posedge CLK);
    model_step();
  endtask

  task automatic idle();
    cyc(0, 0, 8'h00, 0, 0, 0);
  endtask

  logic [15:0] cnt_hold;
  logic [7:0]  pc_hold;

  initial begin
    m_pc = -1; m_mode = -1; m_bub = 0; m_cnt = 0;
    bus.br_taken_i = 0; bus.br_target_i = 0;
    bus.halt_i = 0; bus.stall_i = 0; bus.resume_i = 0;
    // first reset cycle: state unknown, only strobes
    @(negedge CLK); #1;
    chk("rst_en", bus.ifid_en_o, 1);
    chk("rst_fl", bus.ifid_flush_o, 1);
    chk("rst_wb", bus.wb_ff_o, 0);
    @(posedge CLK);
    m_mode = M_RUN; m_pc = 0; m_cnt = 0; m_bub = 0;
    cyc(1, 0, 0, 0, 0, 0);

    // reset then free run
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("fr_pc", o_pc, i);
      chk("fr_wb", o_wb, 1);
      if (i == 0) begin
        chk("rst_st", o_st, 0);
        chk("rst_cnt", o_cnt, 0);
      end
    end
    idle();
    chk("fr_cnt5", o_cnt, 5);

    // wrap at FF
    cyc(0, 1, 8'hFE, 0, 0, 0);
    idle(); idle();
    idle(); chk("wr_fe", o_pc, 8'hFE);
    idle(); chk("wr_ff", o_pc, 8'hFF);
    chk("wr_inc", o_inc, 8'h00);
    idle(); chk("wr_00", o_pc, 8'h00);

    // stall at 10
    cyc(0, 1, 8'h10, 0, 0, 0);
    idle(); idle();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("st_pc", o_pc, 8'h10);
      chk("st_en", o_en, 0);
      if (i > 0) chk("st_state", o_st, 1);
    end
    idle(); chk("st_rel", o_pc, 8'h10);
    idle(); chk("st_nx", o_pc, 8'h11);

    // branch at 05 to 40
    cyc(0, 1, 8'h05, 0, 0, 0);
    idle(); idle();
    cnt_hold = o_cnt;
    cyc(0, 1, 8'h40, 0, 0, 0);
    chk("br_pc", o_pc, 8'h05);
    chk("br_fl0", o_fl, 1);
    cnt_hold = o_cnt;
    idle(); chk("br_fl1", o_fl, 1);
    chk("br_c1", o_cnt, cnt_hold);
    idle(); chk("br_fl2", o_fl, 1);
    chk("br_c2", o_cnt, cnt_hold);
    idle(); chk("br_pc40", o_pc, 8'h40);
    chk("br_wb", o_wb, 1);
    chk("br_run", o_st, 0);

    // halt behaviour
    cyc(0, 0, 0, 1, 0, 0);
    pc_hold = o_pc;
    cyc(0, 1, 8'h77, 1, 1, 0);
    chk("h_st", o_st, 3);
    chk("h_pc", o_pc, pc_hold);
    cyc(0, 0, 0, 1, 0, 1);
    chk("h_both", o_st, 3);
    cyc(0, 0, 0, 0, 0, 1);
    chk("h_res", o_st, 3);
    idle(); chk("h_run", o_st, 0);
    chk("h_pc2", o_pc, pc_hold);

    // reset mid-flush
    cyc(0, 1, 8'h99, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rf_st", o_st, 2);
    idle();
    chk("rf_pc", o_pc, 0);
    chk("rf_run", o_st, 0);
    chk("rf_cnt", o_cnt, 0);
    chk("rf_wb", o_wb, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) == 0),
          8'($urandom),
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters SHALL be:
- PC_W, 8, PC and incremented-PC width.
- RESET_PC, 8'h00, PC value after reset.
- FLUSH_CYCLES, 2, bubble cycles after a taken branch; legal range 1..7.

REQ-002 Ports SHALL be:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- stall_i  in  1  downstream hazard; hold fetch.
- br_taken_i  in  1  taken branch/jump redirect request.
- br_target_i  in  8  redirect target PC.
- halt_i  in  1  stop fetching.
- resume_i  in  1  leave HALT.
- pc_o  out  8  PC presented to the IF/ID register input.
- incre_pc_o  out  8  pc_o+1 presented to the IF/ID register input.
- ifid_en_o  out  1  IF/ID capture enable.
- ifid_flush_o  out  1  squash: IF/ID captures a bubble.
- wb_ff_o  out  1  valid/write-back flag accompanying the fetched instruction.
- state_o  out  2  current FSM state.
- issue_cnt_o  out  16  count of valid issues.

Function
REQ-003 The FSM SHALL have states RUN=0, STALL=1, FLUSH=2, HALT=3, held in a registered state_o.
REQ-004 incre_pc_o SHALL equal (pc_o + 1) mod 256, computed combinationally; 8'hFF+1 SHALL wrap to 8'h00.
REQ-005 Per-cycle input priority SHALL be RST > br_taken_i > halt_i > stall_i.
REQ-006 RUN or STALL, no request asserted:
- pc_o advances to incre_pc_o on the next edge.
- ifid_en_o=1, ifid_flush_o=0, wb_ff_o=1.
- Next state RUN.
REQ-007 RUN or STALL with stall_i=1 (no higher request):
- pc_o held.
- ifid_en_o=0, wb_ff_o=0.
- Next state STALL.
REQ-008 br_taken_i=1 in RUN, STALL or FLUSH:
- Same cycle: ifid_en_o=1, ifid_flush_o=1, wb_ff_o=0.
- Next edge: pc_o<=br_target_i, bubble counter<=FLUSH_CYCLES-1, state FLUSH.
- A branch arriving while already in FLUSH restarts the counter.
REQ-009 FLUSH with no new branch:
- pc_o held; ifid_en_o=1, ifid_flush_o=1, wb_ff_o=0.
- Counter decrements each cycle.
- When counter==0, next state is RUN; pc_o is not advanced in that cycle.
REQ-010 FLUSH SHALL ignore stall_i and halt_i; a halt_i still asserted on return to RUN SHALL take effect then.
REQ-011 halt_i=1 in RUN or STALL (no branch): pc_o held, ifid_en_o=0, wb_ff_o=0, next state HALT.
REQ-012 HALT behaviour:
- Outputs as in REQ-011.
- br_taken_i and stall_i are ignored.
- resume_i=1 with halt_i=0 gives next state RUN; pc_o unchanged.
- halt_i=1 together with resume_i=1 stays in HALT.
REQ-013 issue_cnt_o SHALL increment on every edge where wb_ff_o=1 and SHALL saturate at 16'hFFFF.
REQ-014 All outputs except incre_pc_o SHALL be pure functions of registered state and the current-cycle inputs listed; there are no combinational paths from br_target_i to any output.

Reset
REQ-015 When RST=1 at an edge, the block SHALL load:
- pc_o=RESET_PC, state RUN.
- bubble counter=0, issue_cnt_o=0.
- Any in-progress FLUSH or HALT is abandoned.
REQ-016 In any cycle with RST=1, ifid_en_o SHALL be 1, ifid_flush_o SHALL be 1 and wb_ff_o SHALL be 0, so the IF/ID register captures a bubble.

Structure
REQ-017 State encodings (RUN/STALL/FLUSH/HALT), PC_W and RESET_PC SHALL reside in the shared pipeline package.
REQ-018 The saturating issue counter SHALL be a sub-module named sat_counter (width parameter, enable, synchronous clear); the FSM and PC register stay in fetch_sequencer.

Verification
REQ-019 Reset then free-run 5 cycles -> pc_o sequence 00,01,02,03,04; wb_ff_o=1 each cycle; issue_cnt_o=5.
REQ-020 pc_o=8'hFE, free-run 3 cycles -> pc_o sequence FE,FF,00; incre_pc_o=00 while pc_o=FF.
REQ-021 stall_i high 3 cycles at pc_o=10 -> pc_o stays 10, ifid_en_o=0 for 3 cycles, state_o=1; next cycle pc_o=11.
REQ-022 br_taken_i=1 with target 8'h40 at pc_o=05 -> flush asserted 3 consecutive cycles; then RUN with pc_o=40, wb_ff_o=1; issue_cnt_o unchanged during the flush.
REQ-023 halt_i with stall_i and br_taken_i in HALT -> pc_o frozen, state_o=3; resume_i alone -> state RUN next cycle; halt_i+resume_i together -> remains HALT.
REQ-024 RST asserted during FLUSH (counter=1) -> next cycle pc_o=00, state RUN, issue_cnt_o=0; wb_ff_o=1 on the following cycle.
